// File: rtl/restriction_equiv_sweeper_if.sv
// Sweeper control/status bus: sequencing handshake, restriction mask, netlist drive and results.
interface restriction_equiv_sweeper_if #(
  parameter int unsigned N_IN  = 34,
  parameter int unsigned CNT_W = 35
);
  logic              start;
  logic              abort;
  logic [N_IN-1:0]   fix_mask;
  logic [N_IN-1:0]   fix_val;
  logic [N_IN-1:0]   vec_out;
  logic              ref_y;
  logic              res_y;
  logic              busy;
  logic              done;
  logic              pass;
  logic [CNT_W-1:0]  mismatch_cnt;
  logic [CNT_W-1:0]  vec_count;
  logic [N_IN-1:0]   first_fail_vec;

  modport master (
    output start, abort, fix_mask, fix_val, ref_y, res_y,
    input  vec_out, busy, done, pass, mismatch_cnt, vec_count, first_fail_vec
  );

  modport slave (
    input  start, abort, fix_mask, fix_val, ref_y, res_y,
    output vec_out, busy, done, pass, mismatch_cnt, vec_count, first_fail_vec
  );
endinterface

// File: rtl/restriction_equiv_sweeper.sv
// Exhaustive equivalence sweep of a restricted netlist against its original over the free inputs.
module restriction_equiv_sweeper #(
  parameter int unsigned N_IN   = 34,
  parameter int unsigned SETTLE = 1,
  parameter int unsigned CNT_W  = 35
) (
  input logic                        clk,
  input logic                        rst_n,
  restriction_equiv_sweeper_if.slave bus
);

  localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] SETTLE_RLD = SW'(SETTLE - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  state_t            state, state_nxt;
  logic [N_IN-1:0]   mask_r, mask_nxt;
  logic [N_IN-1:0]   val_r, val_nxt;
  logic [N_IN-1:0]   vec_r, vec_nxt;
  logic [SW-1:0]     settle_r, settle_nxt;
  logic              busy_r, busy_nxt;
  logic              done_r, done_nxt;
  logic              pass_r, pass_nxt;
  logic [CNT_W-1:0]  mm_r, mm_nxt;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt;
  logic [N_IN-1:0]   ff_r, ff_nxt;

  logic              last_c;
  logic              sample_c;
  logic              miss_c;

  // Sweep ends once every free bit of the current vector is one.
  assign last_c   = &(vec_r | mask_r);
  assign sample_c = (state == ST_WAIT) && !bus.abort && (settle_r == '0);
  assign miss_c   = bus.ref_y != bus.res_y;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; abort outranks the sample-cycle transition.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.start) state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (bus.abort)              state_nxt = ST_IDLE;
        else if (sample_c && last_c) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath/output next values: latch on start, count and step the masked vector on samples.
  always_comb begin
    mask_nxt   = mask_r;
    val_nxt    = val_r;
    vec_nxt    = vec_r;
    settle_nxt = settle_r;
    pass_nxt   = pass_r;
    mm_nxt     = mm_r;
    cnt_nxt    = cnt_r;
    ff_nxt     = ff_r;
    busy_nxt   = (state_nxt == ST_WAIT);
    done_nxt   = (state_nxt == ST_DONE);
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          mask_nxt   = bus.fix_mask;
          val_nxt    = bus.fix_val & bus.fix_mask;
          vec_nxt    = bus.fix_val & bus.fix_mask;
          settle_nxt = SETTLE_RLD;
          pass_nxt   = 1'b0;
          mm_nxt     = '0;
          cnt_nxt    = '0;
          ff_nxt     = '0;
        end
      end
      ST_WAIT: begin
        if (bus.abort) begin
          pass_nxt = 1'b0;
        end else if (settle_r != '0) begin
          settle_nxt = settle_r - SW'(1);
        end else begin
          cnt_nxt = cnt_r + CNT_W'(1);
          if (miss_c) begin
            if (!(&mm_r)) mm_nxt = mm_r + CNT_W'(1);
            if (mm_r == '0) ff_nxt = vec_r;
          end
          if (last_c) begin
            pass_nxt = (mm_nxt == '0);
          end else begin
            // Forcing fixed bits to one lets the carry ripple straight across them.
            vec_nxt    = (((vec_r | mask_r) + N_IN'(1)) & ~mask_r) | val_r;
            settle_nxt = SETTLE_RLD;
          end
        end
      end
      default: ;
    endcase
  end

  // Registered datapath and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_r   <= '0;
      val_r    <= '0;
      vec_r    <= '0;
      settle_r <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      pass_r   <= 1'b0;
      mm_r     <= '0;
      cnt_r    <= '0;
      ff_r     <= '0;
    end else begin
      mask_r   <= mask_nxt;
      val_r    <= val_nxt;
      vec_r    <= vec_nxt;
      settle_r <= settle_nxt;
      busy_r   <= busy_nxt;
      done_r   <= done_nxt;
      pass_r   <= pass_nxt;
      mm_r     <= mm_nxt;
      cnt_r    <= cnt_nxt;
      ff_r     <= ff_nxt;
    end
  end

  assign bus.vec_out        = vec_r;
  assign bus.busy           = busy_r;
  assign bus.done           = done_r;
  assign bus.pass           = pass_r;
  assign bus.mismatch_cnt   = mm_r;
  assign bus.vec_count      = cnt_r;
  assign bus.first_fail_vec = ff_r;

endmodule

// File: tb/tb_restriction_equiv_sweeper.sv
// Self-checking bench: directed table, abort/reset/restart corners and randomized masks vs. a model.
module tb_restriction_equiv_sweeper;

  logic clk = 1'b0;
  logic rst_n;
  logic start_a, start_b, abort;
  logic [33:0] mask, val;
  int   mode;
  logic [33:0] fkey;

  int n_pass = 0;
  int n_total = 0;

  logic [33:0] exp_q[$];

  always #5 clk = ~clk;

  restriction_equiv_sweeper_if #(.N_IN(34), .CNT_W(35)) ia ();
  restriction_equiv_sweeper_if #(.N_IN(34), .CNT_W(35)) ib ();

  // Original netlist stand-in and an injected difference for the restricted one.
  function automatic logic ref_f(input logic [33:0] v);
    return ^(v & 34'h2_5A5A_5A5A);
  endfunction

  function automatic logic fault_f(input logic [33:0] v, input int md, input logic [33:0] key);
    case (md)
      1:       return (v == 34'd2) || (v == 34'd3);
      2:       return ((v ^ key) % 34'd5) == 34'd0;
      default: return 1'b0;
    endcase
  endfunction

  assign ia.start = start_a;
  assign ib.start = start_b;
  assign ia.abort = abort;
  assign ib.abort = abort;
  assign ia.fix_mask = mask;
  assign ib.fix_mask = mask;
  assign ia.fix_val = val;
  assign ib.fix_val = val;
  assign ia.ref_y = ref_f(ia.vec_out);
  assign ib.ref_y = ref_f(ib.vec_out);
  assign ia.res_y = ref_f(ia.vec_out) ^ fault_f(ia.vec_out, mode, fkey);
  assign ib.res_y = ref_f(ib.vec_out) ^ fault_f(ib.vec_out, mode, fkey);

  restriction_equiv_sweeper #(.N_IN(34), .SETTLE(1), .CNT_W(35)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia));
  restriction_equiv_sweeper #(.N_IN(34), .SETTLE(3), .CNT_W(35)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, want);
  endtask

  task automatic get_outs(input bit sel, output logic [33:0] vo, output logic bz, output logic dn,
                          output logic ps, output logic [34:0] mm, output logic [34:0] cnt,
                          output logic [33:0] ff);
    if (sel) begin
      vo = ib.vec_out; bz = ib.busy; dn = ib.done; ps = ib.pass;
      mm = ib.mismatch_cnt; cnt = ib.vec_count; ff = ib.first_fail_vec;
    end else begin
      vo = ia.vec_out; bz = ia.busy; dn = ia.done; ps = ia.pass;
      mm = ia.mismatch_cnt; cnt = ia.vec_count; ff = ia.first_fail_vec;
    end
  endtask

  // Model: the i-th vector places the bits of i, in order, onto the free positions.
  task automatic build_exp(input logic [33:0] m, input logic [33:0] v);
    int k;
    logic [33:0] x;
    k = 0;
    for (int b = 0; b < 34; b++) if (!m[b]) k++;
    exp_q.delete();
    for (longint i = 0; i < (longint'(1) << k); i++) begin
      int j;
      x = v & m;
      j = 0;
      for (int b = 0; b < 34; b++) begin
        if (!m[b]) begin
          x[b] = i[j];
          j++;
        end
      end
      exp_q.push_back(x);
    end
  endtask

  task automatic model_finals(input logic [33:0] m, input logic [33:0] v, input int md,
                              input logic [33:0] key, output logic [34:0] cnt,
                              output logic [34:0] mm, output logic [33:0] ff, output bit ps);
    build_exp(m, v);
    cnt = 35'(exp_q.size());
    mm = '0;
    ff = '0;
    foreach (exp_q[i]) begin
      if (fault_f(exp_q[i], md, key)) begin
        if (mm == '0) ff = exp_q[i];
        mm++;
      end
    end
    ps = (mm == '0);
  endtask

  task automatic run(input string nm, input bit sel, input int settle, input logic [33:0] m,
                     input logic [33:0] v, input int md, input int abort_at, input bit poke,
                     input logic [34:0] e_cnt, input logic [34:0] e_mm, input logic [33:0] e_ff,
                     input bit e_pass);
    logic [33:0] vo, ff;
    logic bz, dn, ps;
    logic [34:0] mm, cnt;
    int n, total;
    mask = m;
    val = v;
    mode = md;
    build_exp(m, v);
    n = exp_q.size();
    @(negedge clk);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    total = (abort_at < 0) ? n * settle : abort_at * settle;
    for (int c = 1; c <= total; c++) begin
      get_outs(sel, vo, bz, dn, ps, mm, cnt, ff);
      chk({nm, " vec_out"}, 64'(vo), 64'(exp_q[(c - 1) / settle]));
      chk({nm, " busy"}, 64'(bz), 64'd1);
      chk({nm, " done early"}, 64'(dn), 64'd0);
      if (poke && c == 2) begin
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        mask = ~m;
        val = ~v;
      end
      if (poke && c == 3) begin
        start_a = 1'b0;
        start_b = 1'b0;
      end
      @(negedge clk);
    end
    if (abort_at >= 0) begin
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      get_outs(sel, vo, bz, dn, ps, mm, cnt, ff);
      chk({nm, " abort busy"}, 64'(bz), 64'd0);
      chk({nm, " abort vec_out"}, 64'(vo), 64'(exp_q[abort_at]));
      for (int c = 0; c < 3; c++) begin
        get_outs(sel, vo, bz, dn, ps, mm, cnt, ff);
        chk({nm, " abort no done"}, 64'(dn), 64'd0);
        @(negedge clk);
      end
    end else begin
      get_outs(sel, vo, bz, dn, ps, mm, cnt, ff);
      chk({nm, " done"}, 64'(dn), 64'd1);
      chk({nm, " done busy"}, 64'(bz), 64'd0);
      chk({nm, " last vec"}, 64'(vo), 64'(exp_q[n - 1]));
      @(negedge clk);
      get_outs(sel, vo, bz, dn, ps, mm, cnt, ff);
      chk({nm, " done width"}, 64'(dn), 64'd0);
    end
    get_outs(sel, vo, bz, dn, ps, mm, cnt, ff);
    chk({nm, " vec_count"}, 64'(cnt), 64'(e_cnt));
    chk({nm, " mismatch_cnt"}, 64'(mm), 64'(e_mm));
    chk({nm, " first_fail_vec"}, 64'(ff), 64'(e_ff));
    chk({nm, " pass"}, 64'(ps), 64'(e_pass));
  endtask

  typedef struct {
    string       nm;
    bit          sel;
    int          settle;
    logic [33:0] m;
    logic [33:0] v;
    int          md;
    int          ab;
    bit          poke;
    logic [34:0] cnt;
    logic [34:0] mm;
    logic [33:0] ff;
    bit          ps;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [33:0] vo, ff, free, m, v;
    logic bz, dn, ps;
    logic [34:0] mm, cnt, e_cnt, e_mm;
    logic [33:0] e_ff;
    bit e_ps;
    int k;

    tbl[0] = '{"two_free", 1'b0, 1, ~34'h3, 34'h0, 0, -1, 1'b0, 35'd4, 35'd0, 34'h0, 1'b1};
    tbl[1] = '{"bits5_33", 1'b0, 1, ~(34'h2_0000_0020), 34'h3_FFFF_FFFF, 0, -1, 1'b0,
               35'd4, 35'd0, 34'h0, 1'b1};
    tbl[2] = '{"mismatch23", 1'b0, 1, ~34'h3, 34'h0, 1, -1, 1'b0, 35'd4, 35'd2, 34'h2, 1'b0};
    tbl[3] = '{"settle3", 1'b1, 3, ~34'h3, 34'h2_0000_0001, 0, -1, 1'b1,
               35'd4, 35'd0, 34'h0, 1'b1};
    tbl[4] = '{"abort", 1'b0, 1, ~34'h3, 34'h0, 1, 2, 1'b0, 35'd2, 35'd0, 34'h0, 1'b0};
    tbl[5] = '{"restart_ign", 1'b0, 1, ~34'h3, 34'h0, 1, -1, 1'b1, 35'd4, 35'd2, 34'h2, 1'b0};
    tbl[6] = '{"all_fixed", 1'b0, 1, {34{1'b1}}, 34'h1_2345_6789, 1, -1, 1'b0,
               35'd1, 35'd0, 34'h0, 1'b1};
    tbl[7] = '{"fixed_fail", 1'b0, 1, {34{1'b1}}, 34'h3, 1, -1, 1'b0, 35'd1, 35'd1, 34'h3, 1'b0};

    rst_n = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    abort = 1'b0;
    mask = '0;
    val = '0;
    mode = 0;
    fkey = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    get_outs(1'b0, vo, bz, dn, ps, mm, cnt, ff);
    chk("reset vec_out", 64'(vo), 64'd0);
    chk("reset busy", 64'(bz), 64'd0);
    chk("reset done", 64'(dn), 64'd0);
    chk("reset pass", 64'(ps), 64'd0);
    chk("reset mismatch_cnt", 64'(mm), 64'd0);
    chk("reset vec_count", 64'(cnt), 64'd0);
    chk("reset first_fail_vec", 64'(ff), 64'd0);

    for (int i = 0; i < 8; i++)
      run(tbl[i].nm, tbl[i].sel, tbl[i].settle, tbl[i].m, tbl[i].v, tbl[i].md, tbl[i].ab,
          tbl[i].poke, tbl[i].cnt, tbl[i].mm, tbl[i].ff, tbl[i].ps);

    // Reset pulsed mid-sweep clears everything at once and produces no done.
    mask = ~34'h7;
    val = 34'h1_0000_0000;
    mode = 1;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    get_outs(1'b0, vo, bz, dn, ps, mm, cnt, ff);
    chk("midrst vec_out", 64'(vo), 64'd0);
    chk("midrst busy", 64'(bz), 64'd0);
    chk("midrst vec_count", 64'(cnt), 64'd0);
    chk("midrst mismatch_cnt", 64'(mm), 64'd0);
    chk("midrst first_fail_vec", 64'(ff), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      get_outs(1'b0, vo, bz, dn, ps, mm, cnt, ff);
      chk("midrst no done", 64'(dn), 64'd0);
      chk("midrst idle busy", 64'(bz), 64'd0);
    end

    // Randomized masks, fixed values and mismatch sets against the model.
    for (int r = 0; r < 20; r++) begin
      k = $urandom_range(0, 5);
      free = '0;
      while ($countones(free) < k) free[$urandom_range(0, 33)] = 1'b1;
      m = ~free;
      v = {2'($urandom), 32'($urandom)};
      fkey = {2'($urandom), 32'($urandom)};
      model_finals(m, v, 2, fkey, e_cnt, e_mm, e_ff, e_ps);
      run($sformatf("rand%0d", r), 1'b0, 1, m, v, 2, -1, 1'b0, e_cnt, e_mm, e_ff, e_ps);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/restriction_equiv_sweeper.md
Name: restriction_equiv_sweeper

Overview:
Sequencer that exhaustively checks a restricted single-output combinational function against its original on the subspace selected by a fixed-bit mask. It drives one shared N_IN-bit input vector into two combinational instances: the original PLA netlist and its restriction netlist. It enumerates every assignment of the free (unmasked) inputs, samples both outputs after a programmable settle time, and reports the mismatch count and the first failing vector. It sits beside the benchmark netlists in the autosymmetry experiment harness.

Parameters:
N_IN, 34, width of the input vector driven to both netlists
SETTLE, 1, cycles each vector is held before sampling (must be >=1)
CNT_W, 35, width of the vector and mismatch counters (N_IN+1)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a sweep; sampled only in IDLE
abort  input  1  terminate the sweep; return to IDLE with no done pulse
fix_mask  input  N_IN  1 = bit is fixed, 0 = bit is enumerated; latched on start
fix_val  input  N_IN  values for the fixed bits; latched on start
vec_out  output  N_IN  vector driven to both netlists
ref_y  input  1  output of the original netlist
res_y  input  1  output of the restricted netlist
busy  output  1  high from the cycle after start until done
done  output  1  one-cycle pulse at the end of the sweep
pass  output  1  1 if mismatch_cnt==0; valid from done until next start
mismatch_cnt  output  CNT_W  number of compared vectors where ref_y!=res_y, saturating
vec_count  output  CNT_W  number of vectors compared
first_fail_vec  output  N_IN  vec_out at the first mismatch; 0 if no mismatch

Behaviour:
- Reset (async, rst_n=0): state=IDLE. vec_out=0, busy=0, done=0, pass=0, mismatch_cnt=0, vec_count=0, first_fail_vec=0, settle counter=0. Reset takes effect immediately in any state, including mid-sweep. After reset no done pulse is produced.
- States: IDLE, WAIT, DONE.
- IDLE, on start=1:
  - latch mask_r=fix_mask and val_r=fix_val&fix_mask.
  - vec_out<=val_r; clear mismatch_cnt, vec_count, first_fail_vec, pass; settle<=SETTLE-1.
  - go to WAIT.
  - start in any other state is ignored.
- WAIT:
  - busy=1. vec_out is held stable.
  - If settle!=0, decrement settle.
  - If settle==0 (sample cycle):
    - vec_count+=1.
    - If ref_y!=res_y: mismatch_cnt+=1, saturating at all-ones. If this is the first mismatch, first_fail_vec<=vec_out.
    - If the free bits of vec_out are all ones, i.e. (vec_out|mask_r)=={N_IN{1}}, go to DONE.
    - Otherwise vec_out<=(((vec_out|mask_r)+1)&~mask_r)|val_r and settle<=SETTLE-1. This is a masked increment: fixed bits are constant and free bits count in binary order (LSB free bit fastest).
- DONE: done=1 and busy=0 for exactly one cycle. pass<=(mismatch_cnt==0). Return to IDLE.
- After DONE, vec_out, counters, pass and first_fail_vec hold their values until the next start.
- abort=1 in WAIT: go to IDLE next cycle. busy=0, no done pulse. Counters and vec_out hold their partial values; pass=0. abort has priority over sample-cycle actions in the same cycle. abort in IDLE or DONE has no effect.
- fix_mask all ones: exactly one vector (val_r) is compared.
- fix_mask all zeros: 2^N_IN vectors are compared. vec_count reaches 2^N_IN without overflow.
- Timing: the start edge is cycle 0. For k free bits, the vectors are compared at cycles SETTLE, 2*SETTLE, ..., 2^k*SETTLE. done is high in cycle 2^k*SETTLE+1.
- fix_val bits at free positions have no effect.
- fix_mask and fix_val changes after start have no effect.

Test Plan:
- SETTLE=1, fix_mask=~34'h3, fix_val=0, res_y tied to ref_y -> vec_out 0,1,2,3 on cycles 1–4; done in cycle 5; vec_count=4, mismatch_cnt=0, pass=1, first_fail_vec=0.
- fix_mask with bits 5 and 33 free, fix_val=34'h3_FFFF_FFFF -> vec_out sequence 0x1_FFFF_FFDF, 0x1_FFFF_FFFF, 0x3_FFFF_FFDF, 0x3_FFFF_FFFF; vec_count=4.
- Same as first, with res_y=ref_y^(vec_out==2|vec_out==3) -> mismatch_cnt=2, first_fail_vec=2, pass=0.
- SETTLE=3, 2 free bits -> each vec_out held 3 cycles; done in cycle 13; changing fix_val mid-sweep does not alter the sequence.
- abort asserted in cycle 2 of a 4-vector sweep -> IDLE in cycle 3, no done pulse, vec_count=2, busy=0. A repeat run with rst_n pulsed low mid-sweep -> all outputs 0 immediately, no done pulse.
- start pulsed again while busy -> ignored, sweep completes normally. fix_mask all ones -> single vector, done in cycle 2.
